// File: rtl/i2c_master_pkg.sv
// ----------------------------------------------------------------------------
// i2c_master_pkg
// Shared types and constants for the I2C byte engine: FSM state encoding,
// bit-slot quarter index, address/data widths and the named quarters used
// for SDA sampling and slot completion.
// ----------------------------------------------------------------------------
package i2c_master_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  // Index of the quarter inside one SCL bit slot (q0..q3).
  typedef logic [1:0] quarter_t;

  localparam quarter_t Q_SAMPLE = 2'd2;  // SDA sampled on the last cycle of q2
  localparam quarter_t Q_LAST   = 2'd3;  // slot ends on the last cycle of q3

endpackage

// File: rtl/i2c_quarter_tick.sv
// ----------------------------------------------------------------------------
// i2c_quarter_tick
// Divides the system clock into SCL quarter periods. A counter runs from 0 to
// CLK_DIV-1 while enabled; on its last value it raises tick for one cycle and
// advances the 2-bit quarter index, which wraps q3 -> q0.
//
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous active-high reset
//   enable  in   count while high (engine busy)
//   clear   in   restart at q0, count 0 (command accepted)
//   tick    out  high on the last cycle of the current quarter
//   quarter out  current quarter index
// ----------------------------------------------------------------------------
module i2c_quarter_tick
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     enable,
  input  logic     clear,
  output logic     tick,
  output quarter_t quarter
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CNT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (clear) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (enable) begin
      if (cnt == CNT_MAX) begin
        cnt     <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_byte_engine.sv
// ----------------------------------------------------------------------------
// i2c_byte_engine
// Single-byte I2C master: START, 7-bit address + R/W, address ACK, one data
// byte (write or read), data ACK (slave ACK on write, master NACK on read),
// STOP. Open-drain outputs: *_oe = 1 pulls the line low.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_rw                0 = write, 1 = read
//   cmd_addr, cmd_wdata   slave address and byte to write
//   busy                  transaction in progress
//   done                  one-cycle pulse in the first idle cycle after STOP
//   ack_err               address or write-data NACK, valid with done
//   rd_data               received byte, updated with done on reads
//   scl_oe, sda_oe        pull SCL / SDA low
//   sda_i                 SDA pad input, asynchronous to clock
// ----------------------------------------------------------------------------
module i2c_byte_engine
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              sda_i
);

  state_t              state, state_nxt;
  quarter_t            quarter;
  logic                tick;
  logic                accept;
  logic                slot_end;
  logic                sample;
  logic [2:0]          bit_cnt;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   rx_shift;
  logic [DATA_W-1:0]   wdata_q;
  logic                rw_q;
  logic                err_pend;
  logic                sda_meta, sda_sync;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign slot_end  = tick && (quarter == Q_LAST);
  assign sample    = tick && (quarter == Q_SAMPLE);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock   (clock),
    .reset   (reset),
    .enable  (busy),
    .clear   (accept),
    .tick    (tick),
    .quarter (quarter)
  );

  // SDA comes straight from the pad; two flops before any decision uses it.
  // Reset to 1 so an idle (pulled-up) bus is what the engine sees first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and line drive. Lines are decoded from registered state only,
  // so an asynchronous reset releases both immediately.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_nxt = state;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = START;
      end
      START: begin
        sda_oe = quarter[1];                 // SDA falls mid-slot, SCL high
        if (slot_end) state_nxt = ADDR;
      end
      ADDR: begin
        scl_oe = ~quarter[1];
        sda_oe = ~tx_shift[DATA_W-1];
        if (slot_end && bit_cnt == 3'd7) state_nxt = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_oe = ~quarter[1];
        if (slot_end) state_nxt = err_pend ? STOP : DATA;
      end
      DATA: begin
        scl_oe = ~quarter[1];
        sda_oe = ~tx_shift[DATA_W-1];        // all ones on reads: released
        if (slot_end && bit_cnt == 3'd7) state_nxt = DATA_ACK;
      end
      DATA_ACK: begin
        scl_oe = ~quarter[1];                // SDA released: slave ACK or master NACK
        if (slot_end) state_nxt = STOP;
      end
      STOP: begin
        scl_oe = (quarter == 2'd0);
        sda_oe = ~quarter[1];                // SDA rises while SCL high
        if (slot_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      err_pend <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= '0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        rw_q     <= cmd_rw;
        wdata_q  <= cmd_wdata;
        tx_shift <= {cmd_addr, cmd_rw};
        bit_cnt  <= '0;
        err_pend <= 1'b0;
        ack_err  <= 1'b0;
      end

      if (sample) begin
        unique case (state)
          ADDR_ACK: err_pend <= sda_sync;
          DATA:     if (rw_q) rx_shift <= {rx_shift[DATA_W-2:0], sda_sync};
          DATA_ACK: if (!rw_q && sda_sync) err_pend <= 1'b1;
          default: ;
        endcase
      end

      if (slot_end) begin
        unique case (state)
          ADDR: begin
            bit_cnt <= bit_cnt + 3'd1;
            // Reads load all ones so the master keeps SDA released.
            if (bit_cnt == 3'd7) tx_shift <= rw_q ? '1 : wdata_q;
            else                 tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
          end
          DATA: begin
            bit_cnt  <= bit_cnt + 3'd1;
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
          end
          STOP: begin
            done    <= 1'b1;
            ack_err <= err_pend;
            // On reads err_pend can only come from the address phase.
            if (rw_q && !err_pend) rd_data <= rx_shift;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// ----------------------------------------------------------------------------
// tb_i2c_byte_engine
// Open-drain bus with a behavioural I2C slave at address 0x50. A transaction
// model expands each accepted command into per-cycle expected SCL/SDA drive
// from the slot rules, and one compare process checks every DUT output on
// every falling clock edge. Directed cases pin the model with literal values;
// a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_i2c_byte_engine;

  localparam int D    = 4;
  localparam int SLOT = 4 * D;
  localparam logic [6:0] SLAVE_ADDR = 7'h50;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, busy, done, ack_err;
  logic [7:0] rd_data;
  logic       scl_oe, sda_oe, sda_i;

  logic       slave_low = 1'b0;
  logic       data_ack_en = 1'b1;
  logic [7:0] slave_rbyte = 8'h00;

  assign sda_i = ~(sda_oe | slave_low);

  always #5 clock = ~clock;

  i2c_byte_engine #(.CLK_DIV(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err),
    .rd_data   (rd_data),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  typedef enum {S_IGN, S_ADDR, S_AACK, S_WDATA, S_DACK, S_RDATA, S_MACK} sph_t;
  sph_t       sph = S_IGN;
  int         sbit = 0;
  logic [7:0] sreg = '0;
  logic       srw = 1'b0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic [7:0] seen_addr_byte = '0, seen_wbyte = '0;
  logic       seen_master_ack = 1'b0;
  int         scl_rises = 0, stops_seen = 0;

  always @(negedge clock) begin : slave_proc
    logic scl_n, sda_n;
    scl_n = ~scl_oe;
    sda_n = sda_i;
    if (reset) begin
      sph       = S_IGN;
      slave_low = 1'b0;
    end else if (scl_n && p_scl && p_sda && !sda_n) begin
      sph = S_ADDR; sbit = 0; sreg = '0; slave_low = 1'b0;
    end else if (scl_n && p_scl && !p_sda && sda_n) begin
      sph = S_IGN; slave_low = 1'b0; stops_seen++;
    end else if (scl_n && !p_scl) begin
      scl_rises++;
      case (sph)
        S_ADDR, S_WDATA: begin sreg = {sreg[6:0], sda_n}; sbit++; end
        S_RDATA:         sbit++;
        S_MACK:          seen_master_ack = sda_n;
        default: ;
      endcase
    end else if (!scl_n && p_scl) begin
      case (sph)
        S_ADDR: if (sbit == 8) begin
          seen_addr_byte = sreg;
          if (sreg[7:1] == SLAVE_ADDR) begin
            srw = sreg[0]; slave_low = 1'b1; sph = S_AACK;
          end else sph = S_IGN;
        end
        S_AACK: begin
          sbit = 0; sreg = '0;
          if (srw) begin sph = S_RDATA; slave_low = ~slave_rbyte[7]; end
          else     begin sph = S_WDATA; slave_low = 1'b0; end
        end
        S_RDATA: if (sbit == 8) begin slave_low = 1'b0; sph = S_MACK; end
                 else slave_low = ~slave_rbyte[7-sbit];
        S_WDATA: if (sbit == 8) begin
          seen_wbyte = sreg; slave_low = data_ack_en; sph = S_DACK;
        end
        S_DACK: begin slave_low = 1'b0; sph = S_IGN; end
        S_MACK: sph = S_IGN;
        default: ;
      endcase
    end
    p_scl = scl_n;
    p_sda = ~(sda_oe | slave_low);
  end

  // ---------------- transaction model ----------------
  logic [1:0] exp_q[$];          // {scl_oe, sda_oe} per cycle
  logic       exp_done = 1'b0, exp_ack_err = 1'b0;
  logic [7:0] exp_rd = '0;
  logic       pend_err = 1'b0, pend_upd = 1'b0;
  logic [7:0] pend_rd = '0;
  int         model_pos = 0;

  task automatic push_slot(input logic [1:0] v0, v1, v2, v3);
    for (int i = 0; i < D; i++) exp_q.push_back(v0);
    for (int i = 0; i < D; i++) exp_q.push_back(v1);
    for (int i = 0; i < D; i++) exp_q.push_back(v2);
    for (int i = 0; i < D; i++) exp_q.push_back(v3);
  endtask

  // A bit slot: SCL low for the first half, SDA pulled low for a 0.
  task automatic push_bit(input logic b);
    push_slot({1'b1, ~b}, {1'b1, ~b}, {1'b0, ~b}, {1'b0, ~b});
  endtask

  task automatic build(input logic rw, input logic [6:0] a, input logic [7:0] d);
    logic [7:0] ab;
    logic       addr_ok;
    ab      = {a, rw};
    addr_ok = (a == SLAVE_ADDR);
    push_slot(2'b00, 2'b00, 2'b01, 2'b01);
    for (int i = 7; i >= 0; i--) push_bit(ab[i]);
    push_bit(1'b1);
    if (addr_ok) begin
      for (int i = 7; i >= 0; i--) push_bit(rw ? 1'b1 : d[i]);
      push_bit(1'b1);
    end
    push_slot(2'b11, 2'b01, 2'b00, 2'b00);
    pend_err = !addr_ok || (!rw && !data_ack_en);
    pend_upd = rw && addr_ok;
    pend_rd  = slave_rbyte;
  endtask

  int accepts = 0;

  always @(negedge clock) begin : compare_proc
    logic [1:0] e;
    if (reset) begin
      exp_q.delete();
      exp_done    = 1'b0;
      exp_ack_err = 1'b0;
      exp_rd      = '0;
      model_pos   = 0;
    end
    e = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
    check("cmd_ready", cmd_ready, exp_q.size() == 0);
    check("busy",      busy,      exp_q.size() != 0);
    check("done",      done,      exp_done);
    check("ack_err",   ack_err,   exp_ack_err);
    check("rd_data",   rd_data,   exp_rd);
    check("scl_oe",    scl_oe,    e[1]);
    check("sda_oe",    sda_oe,    e[0]);
    if (!reset) begin
      exp_done = 1'b0;
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        model_pos++;
        if (exp_q.size() == 0) begin
          exp_done    = 1'b1;
          exp_ack_err = pend_err;
          if (pend_upd) exp_rd = pend_rd;
        end
      end else if (cmd_valid) begin
        build(cmd_rw, cmd_addr, cmd_wdata);
        exp_ack_err = 1'b0;
        model_pos   = 0;
        accepts++;
      end
    end
  end

  // ---------------- observation of DUT timing ----------------
  int busy_run = 0, last_busy_run = 0, done_count = 0, b2b_hits = 0;

  always @(negedge clock) begin : timing_mon
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        last_busy_run = busy_run;
        busy_run      = 0;
        done_count++;
        if (cmd_valid && cmd_ready) b2b_hits++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int start;
    int t;
    start     = accepts;
    t         = 0;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    while (accepts == start && t < 100 * SLOT) begin
      @(posedge clock); #1; t++;
    end
    check("accept_bound", accepts != start, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    int t;
    c = done_count;
    t = 0;
    while (done_count == c && t < 100 * SLOT) begin
      @(posedge clock); #1; t++;
    end
    check("done_bound", done_count != c, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  r0, s0, d0, b0;
    int  t;
    logic rw, b2b, pending;
    logic [6:0] a;
    logic [7:0] d;

    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock); #1;

    // Write 0x50 <- 0xA5, all ACKed.
    r0 = scl_rises; s0 = stops_seen;
    issue(1'b0, 7'h50, 8'hA5);
    wait_done();
    check("wr_busy_cycles", last_busy_run, 320);
    check("wr_addr_byte",   seen_addr_byte, 8'hA0);
    check("wr_data_byte",   seen_wbyte, 8'hA5);
    check("wr_ack_err",     ack_err, 0);
    check("wr_scl_rises",   scl_rises - r0, 19);
    check("wr_stops",       stops_seen - s0, 1);

    // Read 0x50, slave returns 0x3C.
    slave_rbyte = 8'h3C; seen_master_ack = 1'b0; s0 = stops_seen;
    issue(1'b1, 7'h50, 8'h00);
    wait_done();
    check("rd_busy_cycles", last_busy_run, 320);
    check("rd_addr_byte",   seen_addr_byte, 8'hA1);
    check("rd_data_val",    rd_data, 8'h3C);
    check("rd_master_nack", seen_master_ack, 1);
    check("rd_ack_err",     ack_err, 0);
    check("rd_stops",       stops_seen - s0, 1);

    // Absent address 0x7F.
    r0 = scl_rises; s0 = stops_seen;
    issue(1'b0, 7'h7F, 8'hFF);
    wait_done();
    check("nak_busy_cycles", last_busy_run, 176);
    check("nak_ack_err",     ack_err, 1);
    check("nak_scl_rises",   scl_rises - r0, 10);
    check("nak_stops",       stops_seen - s0, 1);
    check("nak_rd_held",     rd_data, 8'h3C);

    // Data NACK.
    data_ack_en = 1'b0;
    issue(1'b0, 7'h50, 8'h11);
    wait_done();
    check("dnak_busy_cycles", last_busy_run, 320);
    check("dnak_ack_err",     ack_err, 1);
    check("dnak_data_byte",   seen_wbyte, 8'h11);
    check("dnak_rd_held",     rd_data, 8'h3C);
    data_ack_en = 1'b1;

    // Back-to-back with cmd_valid held, then stray pulses while busy.
    b0 = b2b_hits; d0 = done_count;
    issue(1'b0, 7'h50, 8'h96);
    issue(1'b0, 7'h50, 8'h69);
    check("b2b_in_done_cycle", b2b_hits - b0, 1);
    check("b2b_first_byte",    seen_wbyte, 8'h96);
    for (int k = 0; k < 3; k++) begin
      repeat (40) begin @(posedge clock); #1; end
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h12; cmd_wdata = 8'hEE;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
    end
    wait_done();
    check("b2b_second_byte", seen_wbyte, 8'h69);
    check("b2b_done_count",  done_count - d0, 2);
    check("b2b_ack_err",     ack_err, 0);

    // Reset in the DATA phase, with SCL and SDA both pulled low.
    issue(1'b0, 7'h50, 8'h5A);
    t = 0;
    while (model_pos < 10 * SLOT + 1 && t < 100 * SLOT) begin
      @(posedge clock); #1; t++;
    end
    #1;
    check("pre_rst_scl_oe", scl_oe, 1);
    check("pre_rst_sda_oe", sda_oe, 1);
    reset = 1'b1;
    #1;
    check("rst_scl_oe",    scl_oe, 0);
    check("rst_sda_oe",    sda_oe, 0);
    check("rst_busy",      busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(posedge clock); @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    issue(1'b0, 7'h50, 8'hC3);
    wait_done();
    check("post_rst_busy_cycles", last_busy_run, 320);
    check("post_rst_data_byte",   seen_wbyte, 8'hC3);
    check("post_rst_ack_err",     ack_err, 0);

    // Randomized traffic.
    pending = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b2b = pending && ($urandom_range(0, 2) == 0);
      if (pending && !b2b) begin
        wait_done();
        pending = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      end
      if (!pending) begin
        data_ack_en = ($urandom_range(0, 3) != 0);
        slave_rbyte = 8'($urandom);
      end
      rw = 1'($urandom_range(0, 1));
      if (rw || $urandom_range(0, 2) != 0) a = SLAVE_ADDR;
      else                                 a = 7'($urandom);
      d = 8'($urandom);
      issue(rw, a, d);
      pending = 1'b1;
    end
    wait_done();
    repeat (4) begin @(posedge clock); #1; end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_byte_engine.md
# i2c_byte_engine

Bit-level I2C master engine sitting directly downstream of the AXI4-Lite register bank of AXI_I2C_Master. It accepts one command (7-bit slave address, R/W, one data byte) per handshake. It generates START, the address phase, one data byte, ACK/NACK and STOP on open-drain SCL/SDA. It returns read data and an acknowledge-error flag to the register bank.

## Interface
Parameters:
- CLK_DIV, 250, clock cycles per SCL quarter-period; SCL period = 4*CLK_DIV (100 kHz at 100 MHz); legal range 2..65535

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready
- cmd_rw  in  1  0 = write, 1 = read
- cmd_addr  in  7  slave address
- cmd_wdata  in  8  byte to write (ignored on read)
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  slave NACKed address or write data; valid with done, held until next accept
- rd_data  out  8  received byte; updated with done on reads, held otherwise
- scl_oe  out  1  1 = drive SCL low, 0 = release
- sda_oe  out  1  1 = drive SDA low, 0 = release
- sda_i  in  1  SDA pad input (asynchronous)

## Operation
- Reset values: cmd_ready=1, busy=0, done=0, ack_err=0, rd_data=0, scl_oe=0, sda_oe=0; state IDLE.
- Accept: command registered on cmd_valid & cmd_ready; ack_err cleared and busy set next cycle.
- cmd_valid while busy is ignored; inputs are sampled only at accept.
- sda_i passes through a 2-FF synchronizer before use.
- States: IDLE -> START -> ADDR (8 bits, MSB first: addr[6:0], rw) -> ADDR_ACK -> DATA (8 bits) -> DATA_ACK -> STOP -> IDLE.
- ADDR_ACK with sampled SDA=1: ack_err=1, skip DATA/DATA_ACK, go to STOP.
- Write: DATA drives cmd_wdata MSB first. DATA_ACK samples the slave ACK; NACK sets ack_err.
- Read: DATA releases SDA and shifts sampled bits in MSB first. DATA_ACK releases SDA as the master NACK (last byte).
- Each bit slot is 4 quarters q0..q3, each lasting CLK_DIV cycles:
  - Data/ACK slot: q0 SCL low, SDA updated at q0 start; q1 SCL low; q2 SCL high; q3 SCL high; synchronized SDA sampled on the last cycle of q2.
  - START slot: q0,q1 SDA released, SCL released; q2,q3 SDA low, SCL released.
  - STOP slot: q0 SDA low, SCL low; q1 SDA low, SCL released; q2,q3 SDA released, SCL released.
- No clock stretching and no arbitration; SCL is not read back.

## Timing
- Accept to first START quarter: 1 cycle.
- Total transaction: 20 bit slots = 80*CLK_DIV cycles (normal), 11 slots = 44*CLK_DIV cycles (address NACK).
- done pulses in the first IDLE cycle, where cmd_ready is also 1. A new command accepted in that cycle is legal: back-to-back operation with no gap.
- rd_data and ack_err change only in the done cycle (ack_err cleared at accept).
- Reset mid-transaction: lines released immediately and asynchronously; no STOP is generated. The bus may be left mid-byte, which is accepted behaviour.
- Quarter counter width: $clog2(CLK_DIV). Counter wraps at CLK_DIV-1 and advances the quarter index; the bit counter advances on q3 wrap.

## Structure
- Package i2c_master_pkg: state enum (IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP), quarter index type, address/data width constants.
- Sub-module i2c_quarter_tick: CLK_DIV counter producing a one-cycle tick and the 2-bit quarter index. Enabled while busy; cleared on accept.
- The top level holds the FSM, shift registers, bit counter and SDA synchronizer.

## Test plan
Bench uses CLK_DIV=4 and an open-drain bus model with a behavioural slave.
- Write addr=0x50, wdata=0xA5, slave ACKs all -> SDA bits 1010000_0 then 10100101, done after 320 cycles, ack_err=0.
- Read addr=0x50, slave returns 0x3C -> rd_data=0x3C at done, master NACK in DATA_ACK, STOP seen, ack_err=0.
- Write to absent addr=0x7F (no ACK) -> ack_err=1, STOP follows ADDR_ACK, done after 176 cycles, no data bits on SDA.
- Write with data NACK -> ack_err=1, full 320-cycle transaction, rd_data unchanged.
- Back-to-back commands with cmd_valid held -> second accepted in the done cycle, START begins next cycle; cmd_valid pulses while busy are ignored.
- Assert reset during the DATA phase -> scl_oe=sda_oe=0 immediately, cmd_ready=1, busy=0; the next command completes normally.
